// File: rtl/prog_loader_pkg.sv
// Shared definitions for the serial program loader: loader states and
// default sizing of the instruction memory it fills.
package prog_loader_pkg;

    localparam int ADDR_W_DEF    = 15;
    localparam int MAX_WORDS_DEF = 32768;
    localparam int LEN_W         = 16;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/prog_loader_cksum.sv
// Running 8-bit XOR over the bytes of a program image.
module prog_loader_cksum (
    input  logic       clk_i,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [7:0] byte_i,
    output logic [7:0] value_o
);

    logic [7:0] acc_q;

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking, so every flop samples pre-edge values whatever the block order.
        if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q ^ byte_i;
        end
    end

    assign value_o = acc_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses length, words and checksum, writes the
// instruction memory and releases the CPU only after a verified image.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         hi_q, hi_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [15:0]        rom_wdata_q, rom_wdata_d;
    logic               rx_ready_q, rom_we_q, cpu_reset_q, done_q, error_q;
    logic               xfer, ck_en;
    logic [7:0]         ck_value;
    logic [LEN_W-1:0]   len_full;

    assign xfer     = rx_valid && rx_ready_q;
    assign len_full = {len_q[15:8], rx_data};

    prog_loader_cksum u_cksum (
        .clk_i   (CLK),
        .clear_i (reset),
        .en_i    (ck_en),
        .byte_i  (rx_data),
        .value_o (ck_value)
    );

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        ck_en       = 1'b0;
        unique case (state_q)
            S_LEN_HI: if (xfer) begin
                len_d   = {rx_data, len_q[7:0]};
                ck_en   = 1'b1;
                state_d = S_LEN_LO;
            end
            S_LEN_LO: if (xfer) begin
                len_d = len_full;
                ck_en = 1'b1;
                if (len_full == '0)                    state_d = S_CHECK;
                else if (int'(len_full) > MAX_WORDS)   state_d = S_ERR;
                else                                   state_d = S_DATA_HI;
            end
            S_DATA_HI: if (xfer) begin
                hi_d    = rx_data;
                ck_en   = 1'b1;
                state_d = S_DATA_LO;
            end
            S_DATA_LO: if (xfer) begin
                ck_en       = 1'b1;
                rom_addr_d  = ADDR_W'(cnt_q);
                rom_wdata_d = {hi_q, rx_data};
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                cnt_d   = cnt_q + 16'd1;
                state_d = (cnt_d == len_q) ? S_CHECK : S_DATA_HI;
            end
            S_CHECK: if (xfer) begin
                state_d = (rx_data == ck_value) ? S_DONE : S_ERR;
            end
            default: ;  // DONE and ERR swallow bytes until reset
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_LEN_HI;
            len_q       <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            rx_ready_q  <= 1'b1;
            rom_we_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            rx_ready_q  <= (state_d != S_WRITE);
            rom_we_q    <= (state_d == S_WRITE);
            cpu_reset_q <= (state_d != S_DONE);
            done_q      <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERR);
        end
    end

    assign rx_ready  = rx_ready_q;
    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench: a stream-level model predicts every cycle's outputs from
// the bytes the loader has accepted since reset.
module tb_prog_loader;

    localparam int MAXW = 32768;
    typedef logic [7:0] bq_t[$];

    logic        CLK = 1'b0;
    logic        reset, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, rom_we, cpu_reset, done, error;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;

    int n_checks = 0;
    int n_errors = 0;

    prog_loader #(.ADDR_W(15), .MAX_WORDS(MAXW)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 0 = still loading, 1 = done, 2 = error
    function automatic int status_of(input bq_t s);
        int n;
        logic [7:0] x;
        if (s.size() < 2) return 0;
        n = {s[0], s[1]};
        if (n > MAXW) return 2;
        if (s.size() < 3 + 2 * n) return 0;
        x = 8'h00;
        for (int i = 0; i < 2 + 2 * n; i++) x ^= s[i];
        return (s[2 + 2 * n] == x) ? 1 : 2;
    endfunction

    // ---------------- per-cycle model and comparison ----------------
    bq_t         acc_s;
    logic        armed = 1'b0;
    logic        we_now = 1'b0;
    logic [31:0] exp_addr = 0, exp_data = 0;
    logic [31:0] wlog_addr[$], wlog_data[$];

    always @(negedge CLK) begin
        int st, k, n;
        if (armed) begin
            st = status_of(acc_s);
            check("rom_we",    rom_we,    we_now);
            check("rx_ready",  rx_ready,  !we_now);
            check("rom_addr",  rom_addr,  exp_addr);
            check("rom_wdata", rom_wdata, exp_data);
            check("done",      done,      st == 1);
            check("error",     error,     st == 2);
            check("cpu_reset", cpu_reset, st != 1);
            if (rom_we) begin
                wlog_addr.push_back(rom_addr);
                wlog_data.push_back(rom_wdata);
            end
        end
        if (reset) begin
            acc_s.delete();
            wlog_addr.delete();
            wlog_data.delete();
            we_now   = 1'b0;
            exp_addr = 0;
            exp_data = 0;
            armed    = 1'b1;
        end else if (armed && rx_valid && rx_ready) begin
            acc_s.push_back(rx_data);
            k = acc_s.size() - 1;
            we_now = 1'b0;
            if (k >= 3) begin
                n = {acc_s[0], acc_s[1]};
                if (n <= MAXW && k < 2 + 2 * n && (k % 2) == 1) begin
                    we_now   = 1'b1;
                    exp_addr = (k - 3) / 2;
                    exp_data = {acc_s[k-1], acc_s[k]};
                end
            end
        end else begin
            we_now = 1'b0;
        end
    end

    // ---------------- drivers ----------------
    task automatic idle();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(posedge CLK); #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap_max);
        logic ok;
        int   tries;
        repeat ($urandom_range(0, gap_max)) idle();
        rx_valid = 1'b1;
        rx_data  = b;
        tries    = 0;
        do begin
            @(negedge CLK);
            ok = rx_ready;
            @(posedge CLK); #1;
            tries++;
        end while (!ok && tries < 20);
        if (!ok) check("handshake_timeout", 0, 1);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'($urandom_range(0, 1));  // a byte offered alongside reset is dropped
        rx_data  = 8'($urandom);
        reset    = 1'b1;
        @(posedge CLK); #1;
        reset    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic run(input bq_t q, input int gap_max);
        do_reset();
        foreach (q[i]) send(q[i], gap_max);
        repeat (3) idle();
    endtask

    task automatic check_write(input string name, input int idx, input int a, input int d);
        if (wlog_addr.size() > idx) begin
            check({name, "_addr"}, wlog_addr[idx], a);
            check({name, "_data"}, wlog_data[idx], d);
        end else begin
            check({name, "_present"}, wlog_addr.size(), idx + 1);
        end
    endtask

    task automatic check_end(input string name, input int nwr, input logic d, input logic e);
        check({name, "_nwrites"},  wlog_addr.size(), nwr);
        check({name, "_done"},     done,      d);
        check({name, "_error"},    error,     e);
        check({name, "_cpureset"}, cpu_reset, !d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t q;
        int  n, mode;
        logic [7:0] x;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge CLK); #1;
        reset = 1'b0;

        // Checksum byte 0x42 is the XOR of all six preceding bytes, length included.
        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run(q, 0);
        check_write("two_word_w0", 0, 0, 16'h1234);
        check_write("two_word_w1", 1, 1, 16'hABCD);
        check_end("two_word", 2, 1'b1, 1'b0);

        q = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00};
        run(q, 0);
        check_write("bad_ck_w0", 0, 0, 16'hFFFF);
        check_end("bad_ck", 1, 1'b0, 1'b1);

        q = '{8'h00, 8'h00, 8'h00};
        run(q, 0);
        check_end("zero_ok", 0, 1'b1, 1'b0);
        q = '{8'h00, 8'h00, 8'h01};
        run(q, 0);
        check_end("zero_bad", 0, 1'b0, 1'b1);

        do_reset();
        send(8'h80, 0);
        send(8'h01, 0);
        check("oversize_err_now", error, 1'b1);
        repeat (3) idle();
        check_end("oversize", 0, 1'b0, 1'b1);

        do_reset();
        send(8'h00, 0); send(8'h03, 0); send(8'h12, 0);
        q = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFE};
        run(q, 0);
        check_write("midreset_w0", 0, 0, 16'h55AA);
        check_end("midreset", 1, 1'b1, 1'b0);

        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run(q, 4);
        check_write("gaps_w0", 0, 0, 16'h1234);
        check_write("gaps_w1", 1, 1, 16'hABCD);
        check_end("gaps", 2, 1'b1, 1'b0);

        for (int t = 0; t < 30; t++) begin
            q.delete();
            mode = $urandom_range(0, 9);
            n = (mode == 0) ? $urandom_range(MAXW + 1, 65535) : $urandom_range(0, 6);
            q.push_back(n[15:8]);
            q.push_back(n[7:0]);
            if (n <= MAXW) begin
                repeat (2 * n) q.push_back(8'($urandom));
                x = 8'h00;
                foreach (q[i]) x ^= q[i];
                if ($urandom_range(0, 1) == 1) x ^= 8'($urandom_range(1, 255));
                q.push_back(x);
            end
            repeat ($urandom_range(0, 2)) q.push_back(8'($urandom));
            if (mode == 1) begin
                do_reset();
                repeat ($urandom_range(1, 4)) send(8'($urandom), 2);
            end
            run(q, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
